uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receive-side counterpart of the UART transmitter; consumes the serial line that the transmitter drives. Oversamples RX_IN at Prescale× bit rate, majority-votes each bit and deserializes the 8-bit payload LSB first. Optionally checks parity and always checks the stop bit. Delivers each good byte as a one-cycle Data_Valid strobe to the system controller; errored frames are dropped.

Parameters:
DATA_WIDTH, 8, payload bits per frame
PRESCALE_WIDTH, 6, width of Prescale input

Ports:
CLK  input  1  receive clock, Prescale× bit rate
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high; already synchronized upstream
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even, 1 = odd
Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
P_DATA  output  DATA_WIDTH  last good byte, held until the next good frame
Data_Valid  output  1  one-cycle strobe; P_DATA is valid while it is high
Parity_Error  output  1  one-cycle strobe, parity mismatch
Stop_Error  output  1  one-cycle strobe, stop bit sampled 0

Behaviour:
- Reset (RST low, async): state IDLE, counters 0; P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0. Reset mid-frame aborts the frame with no strobe.
- Prescale, PAR_EN and PAR_TYP are latched when the start is detected and are ignored for the rest of the frame. Illegal Prescale values are treated as 8.
- Timing: cycle 0 is the first cycle with RX_IN sampled 0 in IDLE. edge_cnt runs 0..P-1 within each bit. bit_cnt counts bits in the frame.
- Sampling: RX_IN samples taken at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, available by edge_cnt = P/2+2.
- FSM states:
  - IDLE: RX_IN=0 -> START, edge_cnt=1 next cycle.
  - START: if the voted bit is 1 (glitch), go to IDLE at edge_cnt=P-1 with no strobes. Otherwise go to DATA at edge_cnt=P-1.
  - DATA: shift the voted bit into position bit_cnt (LSB first). After 8 bits -> PARITY if PAR_EN, else STOP.
  - PARITY: expected bit = ^data XOR PAR_TYP. On mismatch, Parity_Error pulses at cycle 10P and the FSM returns to IDLE; no Data_Valid.
  - STOP: if the voted bit is 0, Stop_Error pulses and the FSM returns to IDLE. Otherwise P_DATA is loaded and Data_Valid pulses.
- Latency: with N = 10 (no parity) or 11 (parity), the strobe is registered high on cycle N·P, for exactly one cycle. The FSM is in IDLE on that same cycle, so a start bit beginning at cycle N·P is accepted: back-to-back frames need no extra idle time.
- At most one of Data_Valid, Parity_Error or Stop_Error is high in any cycle.
- P_DATA changes only together with Data_Valid. Errored frames leave P_DATA untouched.
- RX_IN toggling between sample points does not affect the result; only the three votes count.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP); constants PRESCALE_8/16/32; PAR_EVEN=0, PAR_ODD=1.
- One natural sub-module: rx_data_sampling. It takes edge_cnt, Prescale and RX_IN, and outputs the 3-sample majority bit plus a sample_done flag.
- FSM, edge/bit counters, deserializer and checkers stay in uart_rx.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 -> Data_Valid high for one cycle at cycle 80, P_DATA=0xA5, no error strobes.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x07, parity bit 1 -> Data_Valid at cycle 176, P_DATA=0x07.
- Same frame but parity bit 0 -> Parity_Error pulses at cycle 160, no Data_Valid, P_DATA keeps its previous value.
- Prescale=8, PAR_EN=0, byte 0x3C with stop bit 0 -> Stop_Error at cycle 80, no Data_Valid. A following good frame 0x55 is received correctly.
- Prescale=32: a 3-cycle low glitch in idle -> no strobes, FSM back in IDLE by cycle 32. Then frames 0x01 and 0xFE sent back-to-back with no idle gap -> two Data_Valid pulses 320 cycles apart with the correct bytes.
- Assert RST low at the 5th data bit of a frame -> all outputs 0 immediately. After release, the next frame 0x81 is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, legal
// oversampling ratios and parity type codes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Anything other than 8/16/32 falls back to 8x oversampling.
    function automatic int unsigned legal_prescale(input int unsigned p);
        if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32)
            return p;
        return PRESCALE_8;
    endfunction

endpackage

// File: rtl/rx_data_sampling.sv
// Three-point sampler around the middle of each bit period; produces the
// 2-of-3 majority bit and a flag that stays high once all votes are in.
module rx_data_sampling #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      rx_in,
    output logic                      sampled_bit,
    output logic                      sample_done
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] half;
    logic [2:0]                votes;

    assign half = prescale >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            votes       <= '0;
            sample_done <= 1'b0;
        end else begin
            if (edge_cnt == half - ONE) votes[0] <= rx_in;
            if (edge_cnt == half)       votes[1] <= rx_in;
            if (edge_cnt == half + ONE) begin
                votes[2]    <= rx_in;
                sample_done <= 1'b1;
            end else if (edge_cnt == prescale - ONE) begin
                sample_done <= 1'b0;
            end
        end
    end

    assign sampled_bit = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, oversampled majority voting, LSB-first
// deserialization, optional parity and mandatory stop-bit checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = PRESCALE_WIDTH'(1);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e                 state, next_state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt, presc_q;
    logic [BW-1:0]             bit_cnt;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_en_q, par_typ_q;
    logic                      sampled_bit, sample_done;
    logic                      start_det, bit_end;
    logic                      dv_nxt, pe_nxt, se_nxt;

    assign start_det = (state == IDLE) && !RX_IN;
    assign bit_end   = (state != IDLE) && sample_done && (edge_cnt == presc_q - P_ONE);

    rx_data_sampling #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampling (
        .clk        (CLK),
        .rst_n      (RST),
        .edge_cnt   (edge_cnt),
        .prescale   (presc_q),
        .rx_in      (RX_IN),
        .sampled_bit(sampled_bit),
        .sample_done(sample_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        dv_nxt     = 1'b0;
        pe_nxt     = 1'b0;
        se_nxt     = 1'b0;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            // A start bit that votes high was line noise; drop back quietly.
            START:  if (bit_end) next_state = sampled_bit ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) begin
                if (sampled_bit != ((^shreg) ^ (par_typ_q == PAR_ODD))) begin
                    pe_nxt     = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = STOP;
                end
            end
            STOP:   if (bit_end) begin
                next_state = IDLE;
                if (sampled_bit) dv_nxt = 1'b1;
                else             se_nxt = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Frame configuration is frozen at start detection; the line sample
    // at detection counts as edge 0, so the counter resumes at 1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            presc_q   <= PRESCALE_WIDTH'(PRESCALE_8);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            if (start_det) begin
                edge_cnt  <= P_ONE;
                presc_q   <= PRESCALE_WIDTH'(legal_prescale(32'(Prescale)));
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end else if (state == IDLE || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + P_ONE;
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == DATA && bit_end) begin
                shreg[bit_cnt] <= sampled_bit;
                bit_cnt        <= bit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            Data_Valid   <= dv_nxt;
            Parity_Error <= pe_nxt;
            Stop_Error   <= se_nxt;
            if (dv_nxt) P_DATA <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are built as per-cycle line waveforms, the
// expected strobe is derived from the three mid-bit votes of that waveform.
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, Parity_Error, Stop_Error;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Prescale    (Prescale),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Parity_Error(Parity_Error),
        .Stop_Error  (Stop_Error)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;       // index of the next rising edge
    bit         chk_en = 1'b0;
    int         exp_ev [int];  // 1 = valid, 2 = parity error, 3 = stop error
    logic [7:0] exp_byte [int];
    logic [7:0] model_pdata = 8'h00;
    int         dv_cyc[$];
    logic [7:0] dv_byte[$];
    int         pe_cyc[$];
    int         se_cyc[$];
    bit         ln[];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    function automatic int legal(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    function automatic bit vote(input int i, input int p);
        int b;
        b = i * p + p / 2 - 1;
        return (int'(ln[b]) + int'(ln[b+1]) + int'(ln[b+2])) >= 2;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            int ev;
            ev = exp_ev.exists(cyc) ? exp_ev[cyc] : 0;
            if (ev == 1) model_pdata = exp_byte[cyc];
            check("cycle", {21'b0, Data_Valid, Parity_Error, Stop_Error, P_DATA},
                  {21'b0, ev == 1, ev == 2, ev == 3, model_pdata});
            if (Data_Valid) begin
                dv_cyc.push_back(cyc);
                dv_byte.push_back(P_DATA);
            end
            if (Parity_Error) pe_cyc.push_back(cyc);
            if (Stop_Error)   se_cyc.push_back(cyc);
        end
    end

    task automatic build_frame(input int p_raw, input bit pen, input bit ptyp, input logic [7:0] d,
                               input bit par_wrong, input bit stop_v, input bit noisy);
        int p, nb, k;
        bit fb[11];
        p  = legal(p_raw);
        nb = pen ? 11 : 10;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        fb[9]    = (^d) ^ ptyp ^ par_wrong;
        fb[nb-1] = stop_v;
        ln = new[nb * p];
        for (int j = 0; j < nb * p; j++) ln[j] = fb[j / p];
        if (noisy) begin
            for (int i = 0; i < nb; i++) begin
                for (int j = 0; j < p; j++) begin
                    k = i * p + j;
                    if (k != 0 && (j < p/2 - 1 || j > p/2 + 1) && $urandom_range(0, 3) == 0)
                        ln[k] = ~ln[k];
                end
                if ($urandom_range(0, 2) == 0) begin
                    k = i * p + p/2 - 1 + int'($urandom_range(0, 2));
                    ln[k] = ~ln[k];
                end
            end
        end
    endtask

    // Predicts the frame outcome from the votes, then drives the line.
    task automatic run_line(input int p_raw, input bit pen, input bit ptyp, input int abort_k,
                            output int start_o);
        int p, e, ev, s;
        logic [7:0] d;
        p  = legal(p_raw);
        ev = 0;
        d  = 8'h00;
        if (vote(0, p)) begin
            e = p;
        end else begin
            for (int i = 0; i < 8; i++) d[i] = vote(i + 1, p);
            s = pen ? 10 : 9;
            e = (s + 1) * p;
            if (pen && (vote(9, p) != ((^d) ^ ptyp))) begin
                ev = 2;
                e  = 10 * p;
            end else begin
                ev = vote(s, p) ? 1 : 3;
            end
        end
        start_o = 0;
        for (int k = 0; k < e; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                start_o  = cyc;
                Prescale = PW'(p_raw);
                PAR_EN   = pen;
                PAR_TYP  = ptyp;
                if (ev != 0) exp_ev[cyc + e] = ev;
                if (ev == 1) exp_byte[cyc + e] = d;
            end else if (k == 1) begin
                Prescale = PW'($urandom_range(0, 63));
                PAR_EN   = 1'($urandom_range(0, 1));
                PAR_TYP  = 1'($urandom_range(0, 1));
            end
            RX_IN = ln[k];
            if (k == abort_k) return;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    initial begin
        int st, st1, n0;
        int plist[10] = '{8, 16, 32, 8, 16, 32, 12, 0, 63, 24};
        #1;
        check("rst_pdata", int'(P_DATA), 0);
        check("rst_dv", int'(Data_Valid), 0);
        check("rst_pe", int'(Parity_Error), 0);
        check("rst_se", int'(Stop_Error), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        chk_en = 1'b1;
        idle(3);

        build_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
        run_line(8, 1'b0, 1'b0, -1, st);
        idle(2);
        check("a5_dv_cycle", dv_cyc.size() > 0 ? dv_cyc[$] - st : -1, 80);
        check("a5_data", int'(P_DATA), 8'hA5);

        build_frame(16, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0);
        run_line(16, 1'b1, 1'b0, -1, st);
        idle(2);
        check("par_ok_dv_cycle", dv_cyc.size() > 0 ? dv_cyc[$] - st : -1, 176);
        check("par_ok_data", int'(P_DATA), 8'h07);

        n0 = dv_cyc.size();
        build_frame(16, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 1'b0);
        run_line(16, 1'b1, 1'b0, -1, st);
        idle(2);
        check("par_err_cycle", pe_cyc.size() > 0 ? pe_cyc[$] - st : -1, 160);
        check("par_err_no_dv", dv_cyc.size(), n0);
        check("par_err_held", int'(P_DATA), 8'h07);

        build_frame(8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_line(8, 1'b0, 1'b0, -1, st);
        idle(2);
        check("stop_err_cycle", se_cyc.size() > 0 ? se_cyc[$] - st : -1, 80);
        check("stop_err_no_dv", dv_cyc.size(), n0);
        build_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
        run_line(8, 1'b0, 1'b0, -1, st);
        idle(2);
        check("after_stop_err", int'(P_DATA), 8'h55);

        // Short low glitch, then two frames with no idle gap.
        n0 = dv_cyc.size();
        ln = new[32];
        foreach (ln[k]) ln[k] = (k >= 3);
        run_line(32, 1'b0, 1'b0, -1, st);
        build_frame(32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        run_line(32, 1'b0, 1'b0, -1, st1);
        build_frame(32, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
        run_line(32, 1'b0, 1'b0, -1, st1);
        idle(2);
        check("b2b_count", dv_cyc.size() - n0, 2);
        if (dv_cyc.size() - n0 == 2) begin
            check("b2b_first_cycle", dv_cyc[$-1] - st, 352);
            check("b2b_spacing", dv_cyc[$] - dv_cyc[$-1], 320);
            check("b2b_byte0", int'(dv_byte[$-1]), 8'h01);
            check("b2b_byte1", int'(dv_byte[$]), 8'hFE);
        end

        // Reset while the fifth data bit is on the line.
        build_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);
        run_line(8, 1'b0, 1'b0, 5 * 8 + 2, st);
        #2;
        chk_en = 1'b0;
        RST    = 1'b0;
        RX_IN  = 1'b1;
        #1;
        check("midrst_pdata", int'(P_DATA), 0);
        check("midrst_dv", int'(Data_Valid), 0);
        check("midrst_pe", int'(Parity_Error), 0);
        check("midrst_se", int'(Stop_Error), 0);
        exp_ev.delete();
        exp_byte.delete();
        model_pdata = 8'h00;
        repeat (2) @(negedge CLK);
        RST    = 1'b1;
        chk_en = 1'b1;
        idle(2);
        build_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        run_line(8, 1'b0, 1'b0, -1, st);
        idle(2);
        check("post_rst_cycle", dv_cyc.size() > 0 ? dv_cyc[$] - st : -1, 80);
        check("post_rst_data", int'(P_DATA), 8'h81);

        repeat (40) begin
            int pr;
            bit pen, ptyp, pw, sv;
            logic [7:0] d;
            pr   = plist[$urandom_range(0, 9)];
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            d    = 8'($urandom_range(0, 255));
            pw   = pen && ($urandom_range(0, 3) == 0);
            sv   = ($urandom_range(0, 7) != 0);
            build_frame(pr, pen, ptyp, d, pw, sv, 1'b1);
            run_line(pr, pen, ptyp, -1, st);
            idle(int'($urandom_range(0, 3)));
        end
        idle(5);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
